// File: rtl/mbtrain_sb_tx_arbiter.sv
// rtl/mbtrain_sb_tx_arbiter.sv - shares the MBTRAIN sideband TX channel between TX-side and RX-side FSMs
module mbtrain_sb_tx_arbiter #(
    parameter int MSG_W          = 4,
    parameter int SUB_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [SUB_W-1:0]       i_substate_id,
    input  logic [MSG_W-1:0]       i_tx_msg,
    input  logic                   i_tx_valid,
    input  logic [MSG_W-1:0]       i_rx_msg,
    input  logic                   i_rx_valid,
    input  logic                   i_sb_busy,
    output logic [SUB_W+MSG_W-1:0] o_sb_msg,
    output logic                   o_sb_valid,
    output logic                   o_tx_grant,
    output logic                   o_rx_grant,
    output logic                   o_tx_busy_negedge_detected,
    output logic                   o_rx_busy_negedge_detected,
    output logic                   o_timeout
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

    state_e                 state_q, state_d;
    logic                   tx_pend_q, tx_pend_d;
    logic                   rx_pend_q, rx_pend_d;
    logic                   tx_vdly_q, rx_vdly_q, busy_dly_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_rx_q, last_rx_d;
    logic                   tx_grant_q, tx_grant_d;
    logic                   rx_grant_q, rx_grant_d;
    logic                   sb_valid_q, sb_valid_d;
    logic [SUB_W+MSG_W-1:0] sb_msg_q, sb_msg_d;
    logic                   tx_done_q, tx_done_d;
    logic                   rx_done_q, rx_done_d;
    logic                   timeout_q, timeout_d;

    logic tx_rise, rx_rise, busy_fall, complete, timeout_hit, finish;
    logic tx_req, rx_req, tx_win, rx_win, launch;

    assign tx_rise     = i_tx_valid & ~tx_vdly_q;
    assign rx_rise     = i_rx_valid & ~rx_vdly_q;
    assign busy_fall   = busy_dly_q & ~i_sb_busy;
    // busy_dly is 0 right after launch, so a fall seen in WAIT_HI is a genuine short pulse
    assign complete    = ((state_q == WAIT_HI) || (state_q == WAIT_LO)) && busy_fall;
    assign timeout_hit = (state_q != IDLE) && !complete && (cnt_q == CNT_LAST);
    assign finish      = complete | timeout_hit;

    // A requester that has already dropped valid is not eligible even if its flag is still set
    assign tx_req = tx_pend_q & i_tx_valid;
    assign rx_req = rx_pend_q & i_rx_valid;
    assign tx_win = tx_req & (~rx_req | last_rx_q);
    assign rx_win = rx_req & ~tx_win;
    assign launch = (state_q == IDLE) && !i_sb_busy && (tx_req || rx_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_pend_q  <= 1'b0;
            rx_pend_q  <= 1'b0;
            tx_vdly_q  <= 1'b0;
            rx_vdly_q  <= 1'b0;
            busy_dly_q <= 1'b0;
            cnt_q      <= '0;
            last_rx_q  <= 1'b1;
            tx_grant_q <= 1'b0;
            rx_grant_q <= 1'b0;
            sb_valid_q <= 1'b0;
            sb_msg_q   <= '0;
            tx_done_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_pend_q  <= tx_pend_d;
            rx_pend_q  <= rx_pend_d;
            tx_vdly_q  <= i_tx_valid;
            rx_vdly_q  <= i_rx_valid;
            busy_dly_q <= i_sb_busy;
            cnt_q      <= cnt_d;
            last_rx_q  <= last_rx_d;
            tx_grant_q <= tx_grant_d;
            rx_grant_q <= rx_grant_d;
            sb_valid_q <= sb_valid_d;
            sb_msg_q   <= sb_msg_d;
            tx_done_q  <= tx_done_d;
            rx_done_q  <= rx_done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_pend_d  = tx_pend_q;
        rx_pend_d  = rx_pend_q;
        cnt_d      = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
        last_rx_d  = last_rx_q;
        tx_grant_d = tx_grant_q;
        rx_grant_d = rx_grant_q;
        sb_valid_d = 1'b0;
        sb_msg_d   = sb_msg_q;
        tx_done_d  = 1'b0;
        rx_done_d  = 1'b0;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d    = SEND;
                    sb_msg_d   = {i_substate_id, tx_win ? i_tx_msg : i_rx_msg};
                    tx_grant_d = tx_win;
                    rx_grant_d = rx_win;
                    sb_valid_d = 1'b1;
                end
            end
            SEND:    state_d = WAIT_HI;
            WAIT_HI: begin
                if (finish)         state_d = IDLE;
                else if (i_sb_busy) state_d = WAIT_LO;
            end
            WAIT_LO: if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (finish) begin
            tx_done_d  = complete & tx_grant_q;
            rx_done_d  = complete & rx_grant_q;
            timeout_d  = timeout_q | timeout_hit;
            last_rx_d  = rx_grant_q;
            tx_grant_d = 1'b0;
            rx_grant_d = 1'b0;
            if (tx_grant_q) tx_pend_d = 1'b0;
            if (rx_grant_q) rx_pend_d = 1'b0;
        end

        // Withdrawal only counts while not owning the channel; a fresh rising edge always wins
        if (tx_pend_q && !i_tx_valid && !tx_grant_q) tx_pend_d = 1'b0;
        if (rx_pend_q && !i_rx_valid && !rx_grant_q) rx_pend_d = 1'b0;
        if (tx_rise) tx_pend_d = 1'b1;
        if (rx_rise) rx_pend_d = 1'b1;

        if (!i_en) begin
            state_d    = IDLE;
            tx_pend_d  = 1'b0;
            rx_pend_d  = 1'b0;
            cnt_d      = '0;
            tx_grant_d = 1'b0;
            rx_grant_d = 1'b0;
            sb_valid_d = 1'b0;
            tx_done_d  = 1'b0;
            rx_done_d  = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    always_comb begin
        o_sb_msg                   = sb_msg_q;
        o_sb_valid                 = sb_valid_q;
        o_tx_grant                 = tx_grant_q;
        o_rx_grant                 = rx_grant_q;
        o_tx_busy_negedge_detected = tx_done_q;
        o_rx_busy_negedge_detected = rx_done_q;
        o_timeout                  = timeout_q;
    end

endmodule
